tx_frame_arbiter: RTL and testbench



---
 rtl/tx_frame_arbiter.sv | 133 +++++++++++++
 tb/tb_tx_frame_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that frames one {AA, code, data, 55} request at a time
// and streams it byte-wise (0x55 first) into the TX FIFO.
module tx_frame_arbiter #(
    parameter int TX_FIFO_LOAD_W = 8,
    parameter int N_REQ          = 4,
    parameter int TX_FIFO_DEPTH  = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [16*N_REQ-1:0]       req_code,
    input  logic [32*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
    input  logic                      txfifo_full,
    output logic                      txfifo_wr,
    output logic [7:0]                txfifo_data,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic [15:0]               frames_sent
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam int unsigned N_REQ_U     = N_REQ;
    localparam logic [63:0] SPACE_LIMIT = 64'(TX_FIFO_DEPTH - 8);

    state_t      state_q, state_d;
    logic [63:0] frame_q, frame_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]  grant_id_q, grant_id_d;
    logic [15:0] frames_sent_q, frames_sent_d;
    logic        busy_q, busy_d;

    logic        space_ok;
    logic        found;
    logic        accept;
    logic [2:0]  winner;
    logic [7:0]  valid_ext;
    logic [15:0] sel_code;
    logic [31:0] sel_data;
    int unsigned cand;

    // Loads above the depth fall outside the limit too, so space_ok stays low.
    assign space_ok = (64'(txfifo_load) <= SPACE_LIMIT);

    always_comb begin
        valid_ext = 8'(req_valid);
        found     = 1'b0;
        winner    = grant_id_q;
        cand      = 0;
        for (int unsigned off = 1; off <= N_REQ_U; off++) begin
            cand = (32'(grant_id_q) + off) % N_REQ_U;
            if (!found && valid_ext[3'(cand)]) begin
                found  = 1'b1;
                winner = 3'(cand);
            end
        end
        sel_code = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ_U; i++) begin
            if (winner == 3'(i)) begin
                sel_code = req_code[16*i +: 16];
                sel_data = req_data[32*i +: 32];
            end
        end
    end

    assign accept = (state_q == IDLE) && space_ok && found;

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        byte_cnt_d    = byte_cnt_q;
        grant_id_d    = grant_id_q;
        frames_sent_d = frames_sent_q;
        busy_d        = busy_q;
        txfifo_wr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    frame_d    = {8'hAA, sel_code, sel_data, 8'h55};
                    grant_id_d = winner;
                    byte_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!txfifo_full) begin
                    txfifo_wr  = 1'b1;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd7) begin
                        frames_sent_d = frames_sent_q + 16'd1;
                        busy_d        = 1'b0;
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < N_REQ_U; i++) begin
            req_ready[i] = accept && (winner == 3'(i));
        end
        txfifo_data = (state_q == SEND) ? 8'(frame_q >> {byte_cnt_q, 3'b000}) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            byte_cnt_q    <= '0;
            grant_id_q    <= 3'(N_REQ - 1);
            frames_sent_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            byte_cnt_q    <= byte_cnt_d;
            grant_id_q    <= grant_id_d;
            frames_sent_q <= frames_sent_d;
            busy_q        <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: a per-cycle byte-queue reference model plus
// directed scenarios with hand-computed byte streams and grant orders.
module tb_tx_frame_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 128;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [16*N-1:0] req_code = '0;
    logic [32*N-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [7:0]      txfifo_load = '0;
    logic            txfifo_full = 1'b0;
    logic            txfifo_wr;
    logic [7:0]      txfifo_data;
    logic            busy;
    logic [2:0]      grant_id;
    logic [15:0]     frames_sent;

    tx_frame_arbiter #(
        .N_REQ(N),
        .TX_FIFO_LOAD_W(8),
        .TX_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_code(req_code),
        .req_data(req_data),
        .req_ready(req_ready),
        .txfifo_load(txfifo_load),
        .txfifo_full(txfifo_full),
        .txfifo_wr(txfifo_wr),
        .txfifo_data(txfifo_data),
        .busy(busy),
        .grant_id(grant_id),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {int cyc; logic [7:0] b;} wrec_t;
    typedef struct {int cyc; int id;} grec_t;
    wrec_t wlog[$];
    grec_t glog[$];

    // Reference model: pending bytes of the frame on the wire, last grant, count.
    logic [7:0] mq[$];
    int m_grant = N - 1;
    int m_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [N-1:0] e_ready;
        logic         e_wr;
        logic [7:0]   e_data;
        logic         e_busy;
        logic         acc;
        int           w;
        logic [15:0]  c;
        logic [31:0]  d;
        cyc++;
        e_ready = '0; e_wr = 1'b0; e_data = '0; acc = 1'b0; w = 0;
        if (!rst_n) begin
            mq.delete();
            m_grant = N - 1;
            m_count = 0;
        end else if (mq.size() > 0) begin
            e_wr   = !txfifo_full;
            e_data = mq[0];
        end else if ((DEPTH - int'(txfifo_load)) >= 8) begin
            for (int k = 1; k <= N; k++) begin
                if (!acc && req_valid[(m_grant + k) % N]) begin
                    acc = 1'b1;
                    w = (m_grant + k) % N;
                end
            end
            if (acc) e_ready[w] = 1'b1;
        end
        e_busy = (mq.size() > 0);
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("txfifo_wr", 64'(txfifo_wr), 64'(e_wr));
        chk("txfifo_data", 64'(txfifo_data), 64'(e_data));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("grant_id", 64'(grant_id), 64'(m_grant));
        chk("frames_sent", 64'(frames_sent), 64'(m_count));

        if (txfifo_wr) wlog.push_back('{cyc: cyc, b: txfifo_data});
        for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back('{cyc: cyc, id: i});

        if (rst_n) begin
            if (acc) begin
                m_grant = w;
                c = req_code[16*w +: 16];
                d = req_data[32*w +: 32];
                mq.push_back(8'h55);
                for (int b = 0; b < 4; b++) mq.push_back(d[8*b +: 8]);
                mq.push_back(c[7:0]);
                mq.push_back(c[15:8]);
                mq.push_back(8'hAA);
            end else if (e_wr) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_count = (m_count + 1) % 65536;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int id);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            #1;
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("accept_wait", 64'(ok), 64'd1);
    endtask

    task automatic set_req(input int id, input logic [15:0] c, input logic [31:0] d);
        req_code[16*id +: 16] = c;
        req_data[32*id +: 32] = d;
    endtask

    task automatic chk_bytes(input string name, input logic [7:0] exp [8]);
        chk({name, "_len"}, 64'(wlog.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < wlog.size()) chk(name, 64'(wlog[i].b), 64'(exp[i]));
            else chk(name, 64'hX, 64'(exp[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp1 [8];
        logic [7:0] exp3 [8];

        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd3);
        chk("rst_frames", 64'(frames_sent), 64'd0);
        chk("rst_wr", 64'(txfifo_wr), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 2.
        wlog.delete(); glog.delete();
        set_req(2, 16'h0004, 32'hDEADBEEF);
        req_valid[2] = 1'b1;
        wait_ready(2);
        tick();
        req_valid[2] = 1'b0;
        repeat (8) tick();
        exp1 = '{8'h55, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h00, 8'hAA};
        chk_bytes("single_bytes", exp1);
        chk("single_frames", 64'(frames_sent), 64'd1);
        chk("single_grant", 64'(grant_id), 64'd2);
        chk("single_pulses", 64'(glog.size()), 64'd1);
        if (wlog.size() == 8 && glog.size() == 1)
            chk("single_latency", 64'(wlog[0].cyc - glog[0].cyc), 64'd1);

        // All four requesters held valid: round-robin from 0.
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        wlog.delete(); glog.delete();
        for (int i = 0; i < N; i++) set_req(i, 16'(16'h0100 + i), 32'(32'h11111111 * (i + 1)));
        req_valid = '1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (glog.size() >= 5) break;
        end
        req_valid = '0;
        repeat (9) tick();
        chk("rr_count", 64'(glog.size()), 64'd5);
        if (glog.size() == 5) begin
            chk("rr_g0", 64'(glog[0].id), 64'd0);
            chk("rr_g1", 64'(glog[1].id), 64'd1);
            chk("rr_g2", 64'(glog[2].id), 64'd2);
            chk("rr_g3", 64'(glog[3].id), 64'd3);
            chk("rr_g4", 64'(glog[4].id), 64'd0);
            for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(glog[i].cyc - glog[i-1].cyc), 64'd9);
        end
        chk("rr_bytes", 64'(wlog.size()), 64'd40);
        chk("rr_frames", 64'(frames_sent), 64'd5);

        // Space gating: load above depth, then 121, then 120.
        glog.delete();
        set_req(0, 16'hC0DE, 32'h01234567);
        req_valid[0] = 1'b1;
        txfifo_load = 8'd200;
        repeat (3) tick();
        txfifo_load = 8'd121;
        repeat (3) tick();
        chk("space_no_accept", 64'(glog.size()), 64'd0);
        txfifo_load = 8'd120;
        #1;
        chk("space_accept", 64'(req_ready), 64'b0001);
        tick();
        req_valid[0] = 1'b0;
        txfifo_load = 8'd0;
        repeat (8) tick();
        chk("space_frames", 64'(frames_sent), 64'd6);
        chk("space_grant", 64'(grant_id), 64'd0);

        // Backpressure: full for 5 cycles after bytes 0..2.
        wlog.delete();
        set_req(1, 16'h1234, 32'h0A0B0C0D);
        req_valid[1] = 1'b1;
        wait_ready(1);
        tick();
        req_valid[1] = 1'b0;
        repeat (2) tick();
        tick();
        txfifo_full = 1'b1;
        repeat (4) tick();
        tick();
        txfifo_full = 1'b0;
        repeat (5) tick();
        exp3 = '{8'h55, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h34, 8'h12, 8'hAA};
        chk_bytes("bp_bytes", exp3);
        if (wlog.size() == 8) begin
            chk("bp_stall_gap", 64'(wlog[3].cyc - wlog[2].cyc), 64'd6);
            chk("bp_frame_span", 64'(wlog[7].cyc - wlog[0].cyc), 64'd12);
        end
        chk("bp_frames", 64'(frames_sent), 64'd7);

        // Asynchronous reset in the middle of a frame.
        wlog.delete();
        set_req(1, 16'h5A5A, 32'hCAFEF00D);
        req_valid[1] = 1'b1;
        wait_ready(1);
        tick();
        req_valid[1] = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", 64'(txfifo_wr), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_frames", 64'(frames_sent), 64'd0);
        chk("mid_rst_grant", 64'(grant_id), 64'd3);
        chk("mid_rst_partial", 64'(wlog.size()), 64'd5);
        repeat (2) tick();
        rst_n = 1'b1;
        wlog.delete();
        set_req(2, 16'h0002, 32'h00000077);
        req_valid[2] = 1'b1;
        wait_ready(2);
        tick();
        req_valid[2] = 1'b0;
        repeat (8) tick();
        chk("post_rst_len", 64'(wlog.size()), 64'd8);
        if (wlog.size() == 8) begin
            chk("post_rst_b0", 64'(wlog[0].b), 64'h55);
            chk("post_rst_b1", 64'(wlog[1].b), 64'h77);
            chk("post_rst_b7", 64'(wlog[7].b), 64'hAA);
        end
        chk("post_rst_frames", 64'(frames_sent), 64'd1);

        // Counter wrap and withdrawn requests.
        force dut.frames_sent_q = 16'hFFFF;
        m_count = 16'hFFFF;
        #1;
        release dut.frames_sent_q;
        tick();
        chk("wrap_preload", 64'(frames_sent), 64'hFFFF);
        glog.delete();
        set_req(3, 16'h3333, 32'h33333333);
        txfifo_load = 8'd125;
        req_valid[3] = 1'b1;
        repeat (3) tick();
        req_valid[3] = 1'b0;
        txfifo_load = 8'd0;
        tick();
        chk("withdraw_idle_none", 64'(glog.size()), 64'd0);
        chk("withdraw_idle_grant", 64'(grant_id), 64'd2);
        set_req(0, 16'hBEEF, 32'h00000000);
        req_valid[0] = 1'b1;
        wait_ready(0);
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 16'h1111, 32'h11111111);
        req_valid[1] = 1'b1;
        repeat (3) tick();
        req_valid[1] = 1'b0;
        repeat (5) tick();
        chk("wrap_frames", 64'(frames_sent), 64'd0);
        chk("withdraw_grant", 64'(grant_id), 64'd0);
        chk("withdraw_pulses", 64'(glog.size()), 64'd1);
        if (glog.size() == 1) chk("withdraw_winner", 64'(glog[0].id), 64'd0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
